// File: rtl/mac_controller.sv
// rtl/mac_controller.sv - MDIO/MIIM management master: 64-bit clause-22 frames on phy_mdc/phy_mdio.
module mac_controller #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
  output logic [15:0] miim_rddata,
  output logic        miim_rddata_valid,
  output logic        miim_busy,
  output logic        phy_mdc,
  inout  wire         phy_mdio
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_M1  = DW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TA,
    DATA
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [62:0]   shreg;
  logic [15:0]   rd_shift;
  logic          mdo;
  logic          oe;
  logic          is_write;

  logic [1:0]  req_op;
  logic [63:0] req_frame;

  // Write wins when both strobes arrive together.
  assign req_op    = miim_wren ? 2'b01 : 2'b10;
  assign req_frame = {32'hFFFF_FFFF, 2'b01, req_op, miim_phyad, miim_regad, 2'b10,
                      (miim_wren ? miim_wrdata : 16'h0000)};

  assign phy_mdio = oe ? mdo : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      rd_shift          <= '0;
      mdo               <= 1'b0;
      oe                <= 1'b0;
      is_write          <= 1'b0;
      phy_mdc           <= 1'b0;
      miim_busy         <= 1'b0;
      miim_rddata       <= 16'h0000;
      miim_rddata_valid <= 1'b0;
    end else begin
      miim_rddata_valid <= 1'b0;
      case (state)
        IDLE: begin
          phy_mdc <= 1'b0;
          if (miim_wren || miim_rden) begin
            state     <= PREAMBLE;
            is_write  <= miim_wren;
            shreg     <= req_frame[62:0];
            mdo       <= req_frame[63];
            oe        <= 1'b1;
            miim_busy <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end
        end
        default: begin
          if (div_cnt == DIV_LAST) begin
            // Bit boundary: MDC falls and the next bit goes out while MDC is low.
            div_cnt <= '0;
            phy_mdc <= 1'b0;
            if (bit_cnt == 6'd63) begin
              state     <= IDLE;
              miim_busy <= 1'b0;
              oe        <= 1'b0;
              mdo       <= 1'b0;
              bit_cnt   <= '0;
              if (!is_write) begin
                miim_rddata       <= rd_shift;
                miim_rddata_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              mdo     <= shreg[62];
              shreg   <= {shreg[61:0], 1'b0};
              if (bit_cnt == 6'd31) state <= HEADER;
              if (bit_cnt == 6'd45) begin
                state <= TA;
                if (!is_write) oe <= 1'b0;
              end
              if (bit_cnt == 6'd47) state <= DATA;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == HALF_M1) begin
              phy_mdc <= 1'b1;
              if (state == DATA && !is_write) rd_shift <= {rd_shift[14:0], phy_mdio};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_controller.sv
// tb/tb_mac_controller.sv - table-driven checks of mac_controller frames, reads, resets and idle.
module tb_mac_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  phyad = '0;
  logic [4:0]  regad = '0;
  logic [15:0] wrdata = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [15:0] rddata;
  logic        rddata_valid;
  logic        busy;
  logic        mdc;
  wire         mdio;
  logic        phy_oe = 1'b0;
  logic        phy_bit = 1'b0;

  pullup (mdio);
  assign mdio = phy_oe ? phy_bit : 1'bz;

  int checks = 0;
  int errors = 0;

  mac_controller #(.CLK_DIV(20)) dut (
    .clk(clk),
    .rst(rst),
    .miim_phyad(phyad),
    .miim_regad(regad),
    .miim_wrdata(wrdata),
    .miim_wren(wren),
    .miim_rden(rden),
    .miim_rddata(rddata),
    .miim_rddata_valid(rddata_valid),
    .miim_busy(busy),
    .phy_mdc(mdc),
    .phy_mdio(mdio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] wrdata;
    logic [15:0] phy_data;
    logic        poke;
    logic [63:0] exp_bits;
    logic        exp_valid;
    logic [15:0] exp_rddata;
  } vec_t;

  vec_t vecs[5];
  vec_t post_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [63:0] got;
    int busy_cnt, highs, rises, falls, valid_cnt;
    logic prev_mdc, valid_at_end, ended;
    got = '1; busy_cnt = 0; highs = 0; rises = 0; falls = 0; valid_cnt = 0;
    prev_mdc = 1'b0; valid_at_end = 1'b0; ended = 1'b0;
    @(negedge clk);
    wren = v.wr; rden = v.rd; phyad = v.phyad; regad = v.regad; wrdata = v.wrdata;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; phyad = 5'h1F; regad = 5'h1F; wrdata = 16'hDEAD;
    for (int cyc = 0; cyc < 1400; cyc++) begin
      if (!busy) begin
        valid_at_end = rddata_valid;
        if (rddata_valid) valid_cnt++;
        ended = 1'b1;
        break;
      end
      busy_cnt++;
      if (rddata_valid) valid_cnt++;
      if (mdc) highs++;
      if (mdc && !prev_mdc) begin
        if (rises < 64) got[63-rises] = mdio;
        rises++;
      end
      if (!mdc && prev_mdc) begin
        falls++;
        phy_oe  = v.rd && !v.wr && falls >= 48 && falls <= 63;
        phy_bit = (falls >= 48 && falls <= 63) ? v.phy_data[63-falls] : 1'b0;
      end
      if (v.poke && cyc == 100) begin
        wren = 1'b1; rden = 1'b1; phyad = 5'h0A; regad = 5'h15; wrdata = 16'h5555;
      end else if (v.poke && cyc == 101) begin
        wren = 1'b0; rden = 1'b0;
      end
      prev_mdc = mdc;
      @(negedge clk);
    end
    phy_oe = 1'b0;
    #1;
    chk({tag, "_ended"}, 64'(ended), 64'd1);
    chk({tag, "_bits"}, got, v.exp_bits);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd1280);
    chk({tag, "_mdc_high_cycles"}, 64'(highs), 64'd640);
    chk({tag, "_valid_at_busy_fall"}, 64'(valid_at_end), 64'(v.exp_valid));
    chk({tag, "_valid_count"}, 64'(valid_cnt), 64'(v.exp_valid));
    chk({tag, "_rddata"}, 64'(rddata), 64'(v.exp_rddata));
    chk({tag, "_mdc_low_after"}, 64'(mdc), 64'd0);
    chk({tag, "_mdio_released_after"}, 64'(mdio), 64'd1);
    @(negedge clk);
    chk({tag, "_valid_one_cycle"}, 64'(rddata_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd1,  5'd0,  16'h3100, 16'h0000, 1'b0,
                {32'hFFFF_FFFF, 32'h5082_3100}, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 5'd1,  5'd4,  16'h0000, 16'hA5C3, 1'b0,
                {32'hFFFF_FFFF, 32'h6093_A5C3}, 1'b1, 16'hA5C3};
    vecs[2] = '{1'b1, 1'b0, 5'd3,  5'h11, 16'h1234, 16'h0000, 1'b1,
                {32'hFFFF_FFFF, 32'h51C6_1234}, 1'b0, 16'hA5C3};
    vecs[3] = '{1'b1, 1'b1, 5'd2,  5'd3,  16'hBEEF, 16'h0000, 1'b0,
                {32'hFFFF_FFFF, 32'h510E_BEEF}, 1'b0, 16'hA5C3};
    vecs[4] = '{1'b0, 1'b1, 5'h1F, 5'h1F, 16'h0000, 16'h0001, 1'b0,
                {32'hFFFF_FFFF, 32'h6FFF_0001}, 1'b1, 16'h0001};
    post_rst = '{1'b1, 1'b0, 5'd1, 5'd0, 16'h3100, 16'h0000, 1'b0,
                 {32'hFFFF_FFFF, 32'h5082_3100}, 1'b0, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_valid", 64'(rddata_valid), 64'd0);
    chk("rst_rddata", 64'(rddata), 64'h0);
    chk("rst_mdio", 64'(mdio), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset in the middle of a read, at bit 40.
    begin
      int rises;
      logic prev_mdc;
      rises = 0; prev_mdc = 1'b0;
      @(negedge clk);
      rden = 1'b1; phyad = 5'd1; regad = 5'd4;
      @(negedge clk);
      rden = 1'b0;
      for (int cyc = 0; cyc < 2000 && rises < 41; cyc++) begin
        if (mdc && !prev_mdc) rises++;
        prev_mdc = mdc;
        if (rises < 41) @(negedge clk);
      end
      chk("midrst_reached_bit40", 64'(rises), 64'd41);
      chk("midrst_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_mdc", 64'(mdc), 64'd0);
      chk("midrst_valid", 64'(rddata_valid), 64'd0);
      chk("midrst_mdio", 64'(mdio), 64'd1);
      chk("midrst_rddata", 64'(rddata), 64'h0);
      @(negedge clk);
      rst = 1'b0;
    end
    run_vec("post_rst", post_rst);

    // Idle for 1000 cycles: nothing may move.
    begin
      int mdc_hi, busy_hi, mdio_lo;
      mdc_hi = 0; busy_hi = 0; mdio_lo = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
        @(negedge clk);
        if (mdc) mdc_hi++;
        if (busy) busy_hi++;
        if (mdio !== 1'b1) mdio_lo++;
      end
      chk("idle_mdc_high", 64'(mdc_hi), 64'd0);
      chk("idle_busy_high", 64'(busy_hi), 64'd0);
      chk("idle_mdio_driven", 64'(mdio_lo), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
